// File: rtl/click_sync_sink.sv
// ============================================================================
// Module  : click_sync_sink
// Brief   : Two-phase click (drive/free) to synchronous valid/ready converter
//           with a drive-toggle synchronizer and a small capture FIFO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module click_sync_sink #(
    parameter int DW          = 32,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_drive,
    input  logic [DW-1:0]            i_data,
    output logic                     o_free,
    output logic                     o_valid,
    output logic [DW-1:0]            o_data,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   drive_seen_q, drive_seen_d;
    logic                   free_q, free_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [DW-1:0]          mem_q [DEPTH];

    logic w_drive_sync;
    logic w_pending;
    logic w_full;
    logic w_capture;
    logic w_pop;

    assign w_drive_sync = sync_q[SYNC_STAGES-1];
    assign w_pending    = (w_drive_sync != drive_seen_q);
    // Fullness uses the pre-pop count so i_ready never reaches o_free combinationally.
    assign w_full       = (count_q == C_DEPTH);
    assign w_capture    = w_pending && !w_full;
    assign w_pop        = (count_q != '0) && i_ready;

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], i_drive};
        drive_seen_d = drive_seen_q;
        free_d       = free_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        if (w_capture) begin
            wr_ptr_d     = wr_ptr_q + AW'(1);
            drive_seen_d = w_drive_sync;
            free_d       = ~free_q;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({w_capture, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_pending && w_full) state_d = ST_STALL;
            ST_STALL: if (w_capture)           state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            sync_q       <= '0;
            drive_seen_q <= 1'b0;
            free_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            drive_seen_q <= drive_seen_d;
            free_q       <= free_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage carries no reset; the head is only meaningful while o_valid is high.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    assign o_free  = free_q;
    assign o_valid = (count_q != '0);
    assign o_data  = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_click_sync_sink.sv
// ============================================================================
// Module  : tb_click_sync_sink
// Brief   : Self-checking bench for click_sync_sink with a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_click_sync_sink;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rstn;
    logic          i_drive;
    logic [DW-1:0] i_data;
    logic          o_free;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          i_ready;
    logic [CW-1:0] o_count;

    int checks;
    int errors;

    click_sync_sink #(
        .DW          (DW),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .i_drive (i_drive),
        .i_data  (i_data),
        .o_free  (o_free),
        .o_valid (o_valid),
        .o_data  (o_data),
        .i_ready (i_ready),
        .o_count (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sender side of the click stage: one toggle, then wait for the acknowledge.
    task automatic send(input logic [DW-1:0] d, input int budget, output bit ok);
        i_data  = d;
        i_drive = ~i_drive;
        ok      = 1'b0;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (o_free === i_drive) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        i_drive = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (o_valid !== 1'b0 || o_free !== 1'b0 || o_count !== '0) begin
            errors++;
            $display("FAIL reset_state valid=%b free=%b count=%0d, required 0/0/0", o_valid, o_free, o_count);
        end
    endtask

    task automatic test_single();
        do_reset();
        i_data  = 32'hA5A5_0001;
        i_drive = 1'b1;
        tick();
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_free !== 1'b0) begin
            errors++;
            $display("FAIL single_early valid=%b free=%b before edge k+2, required 0/0", o_valid, o_free);
        end
        tick();
        checks++;
        if (o_free !== 1'b1 || o_valid !== 1'b1 || o_data !== 32'hA5A5_0001 || o_count !== CW'(1)) begin
            errors++;
            $display("FAIL single_capture free=%b valid=%b data=%h count=%0d, required 1/1/a5a50001/1", o_free, o_valid, o_data, o_count);
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_count !== '0) begin
            errors++;
            $display("FAIL single_pop valid=%b count=%0d, required 0/0", o_valid, o_count);
        end
        // i_ready while empty must not underflow.
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        checks++;
        if (o_count !== '0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_ready count=%0d valid=%b, required 0/0", o_count, o_valid);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int toggles;
        logic [DW-1:0] exp;
        do_reset();
        toggles = 0;
        for (int i = 0; i < DEPTH; i++) begin
            send(32'h10 + DW'(i), 8, ok);
            if (ok) toggles++;
        end
        checks++;
        if (toggles != DEPTH || o_count !== CW'(DEPTH)) begin
            errors++;
            $display("FAIL bp_fill toggles=%0d count=%0d, required %0d/%0d", toggles, o_count, DEPTH, DEPTH);
        end
        send(32'h14, 6, ok);
        checks++;
        if (ok || o_count !== CW'(DEPTH)) begin
            errors++;
            $display("FAIL bp_stall acked=%b count=%0d, required 0/%0d", ok, o_count, DEPTH);
        end
        checks++;
        if (o_data !== 32'h10) begin
            errors++;
            $display("FAIL bp_head data=%h, required 10", o_data);
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        checks++;
        if (o_count !== CW'(DEPTH - 1) || o_free === i_drive) begin
            errors++;
            $display("FAIL bp_deferred count=%0d free=%b, required %0d and no ack yet", o_count, o_free, DEPTH - 1);
        end
        tick();
        checks++;
        if (o_count !== CW'(DEPTH) || o_free !== i_drive) begin
            errors++;
            $display("FAIL bp_late_capture count=%0d free=%b, required %0d/%b", o_count, o_free, DEPTH, i_drive);
        end
        for (int i = 1; i <= DEPTH; i++) begin
            exp = 32'h10 + DW'(i);
            checks++;
            if (o_valid !== 1'b1 || o_data !== exp) begin
                errors++;
                $display("FAIL bp_drain[%0d] valid=%b data=%h, required 1/%h", i, o_valid, o_data, exp);
            end
            i_ready = 1'b1;
            tick();
            i_ready = 1'b0;
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        do_reset();
        send(32'h20, 8, ok);
        send(32'h21, 8, ok);
        i_data  = 32'h22;
        i_drive = ~i_drive;
        tick();
        tick();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        checks++;
        if (o_count !== CW'(2) || o_data !== 32'h21 || o_free !== i_drive) begin
            errors++;
            $display("FAIL push_pop count=%0d data=%h free=%b, required 2/21/%b", o_count, o_data, o_free, i_drive);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int bad;
        bad = 0;
        do_reset();
        for (int i = 0; i < 2 * DEPTH + 1; i++) begin
            send(DW'(i), 8, ok);
            if (!ok || o_data !== DW'(i) || o_valid !== 1'b1) bad++;
            i_ready = 1'b1;
            tick();
            i_ready = 1'b0;
        end
        checks++;
        if (bad != 0 || o_count !== '0) begin
            errors++;
            $display("FAIL wrap_order bad=%0d count=%0d, required 0/0", bad, o_count);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        for (int i = 0; i < 3; i++) send(32'h30 + DW'(i), 8, ok);
        i_data  = 32'h33;
        i_drive = ~i_drive;
        tick();
        #2;
        rstn    = 1'b0;
        i_drive = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_free !== 1'b0 || o_count !== '0) begin
            errors++;
            $display("FAIL async_reset valid=%b free=%b count=%0d, required 0/0/0", o_valid, o_free, o_count);
        end
        tick();
        rstn = 1'b1;
        repeat (5) tick();
        checks++;
        if (o_count !== '0 || o_free !== 1'b0) begin
            errors++;
            $display("FAIL post_reset count=%0d free=%b, required 0/0", o_count, o_free);
        end
    endtask

    // Random traffic against a queue of sent-but-not-popped tokens.
    task automatic test_random();
        logic [DW-1:0] model[$];
        logic [DW-1:0] d;
        int outstanding;
        int sent;
        int popped;
        int bad;
        do_reset();
        sent   = 0;
        popped = 0;
        bad    = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            outstanding = (o_free !== i_drive) ? 1 : 0;
            if (o_count !== CW'(model.size() - outstanding)) bad++;
            if (o_count > CW'(DEPTH)) bad++;
            i_ready = (cyc < 560) ? ($urandom_range(0, 2) == 0) : 1'b1;
            if (o_valid && i_ready) begin
                if (model.size() == 0 || o_data !== model[0]) bad++;
                if (model.size() != 0) void'(model.pop_front());
                popped++;
            end
            if (outstanding == 0 && cyc < 540 && $urandom_range(0, 1) == 1) begin
                d = $urandom;
                i_data  = d;
                i_drive = ~i_drive;
                model.push_back(d);
                sent++;
            end
            tick();
        end
        i_ready = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL random_stream bad_cycles=%0d, required 0", bad);
        end
        checks++;
        if (popped != sent || sent < 20 || o_count !== '0 || o_free !== i_drive) begin
            errors++;
            $display("FAIL random_settle sent=%0d popped=%0d count=%0d free=%b drive=%b, required equal/0/parity", sent, popped, o_count, o_free, i_drive);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rstn    = 1'b0;
        i_drive = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        test_reset();
        test_single();
        test_backpressure();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
